axi_lite_mem_slave: RTL



---
 rtl/axi_lite_slave_pkg.sv | 30 +++
 rtl/axi_slave_mem_array.sv | 39 +++
 rtl/axi_lite_mem_slave.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_pkg.sv
// Shared types and constants for the AXI4-Lite slave memory.
//   SLV_STATE   : transaction FSM states
//   RESP_*      : AXI4-Lite response codes
//   DEF_*       : default geometry, base address and latencies
package axi_lite_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      WR_DATA,
      WR_WAIT,
      WR_RESP
   } SLV_STATE;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int                    DEF_ADDR_W    = 17;
   localparam int                    DEF_DATA_W    = 32;
   localparam int                    DEF_DEPTH     = 256;
   localparam logic [DEF_ADDR_W-1:0] DEF_BASE_ADDR = 17'h10000;
   localparam int                    DEF_RD_LAT    = 2;
   localparam int                    DEF_WR_LAT    = 1;

   // Latency counters hold 0..15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/axi_slave_mem_array.sv
// Word array behind the slave: DEPTH x DATA_W, cleared by reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write enable (one write port, written at the clock edge)
//   waddr      : write word index
//   wdata      : write data
//   raddr      : read word index (combinational read port)
//   rdata      : read data
module axi_slave_mem_array #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array is built from resettable flops rather than a RAM macro
   // so that a reset mid-run leaves every word at zero; that is the behaviour
   // the simulation/formal harness relies on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave memory: one transaction at a time, programmable response
// latency, decode errors for misaligned or out-of-window addresses.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   AR_VALID/AR_ADDR/AR_READY  : read address channel
//   R_VALID/R_DATA/R_RESP/R_READY : read data channel
//   AW_VALID/AW_ADDR/AW_READY  : write address channel
//   W_VALID/W_DATA/W_READY     : write data channel
//   B_VALID/B_RESP/B_READY     : write response channel
module axi_lite_mem_slave
   import axi_lite_slave_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                DEPTH     = DEF_DEPTH,
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int                RD_LAT    = DEF_RD_LAT,
   parameter int                WR_LAT    = DEF_WR_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              AR_VALID,
   input  logic [ADDR_W-1:0] AR_ADDR,
   output logic              AR_READY,
   output logic              R_VALID,
   output logic [DATA_W-1:0] R_DATA,
   output logic [1:0]        R_RESP,
   input  logic              R_READY,
   input  logic              AW_VALID,
   input  logic [ADDR_W-1:0] AW_ADDR,
   output logic              AW_READY,
   input  logic              W_VALID,
   input  logic [DATA_W-1:0] W_DATA,
   output logic              W_READY,
   output logic              B_VALID,
   output logic [1:0]        B_RESP,
   input  logic              B_READY
);

   localparam int               IDX_W    = $clog2(DEPTH);
   localparam int               TAG_LSB  = IDX_W + 2;
   localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);

   SLV_STATE          state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              latch_ar, latch_aw, load_rdata, load_bresp, mem_we;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_resp, wr_resp;
   logic [DATA_W-1:0] mem_rdata;

   // Misalignment takes priority over an out-of-window address.
   function automatic logic [1:0] decode(input logic [ADDR_W-1:0] a);
      if (a[1:0] != 2'b00) begin
         return RESP_SLVERR;
      end else if (a[ADDR_W-1:TAG_LSB] != BASE_ADDR[ADDR_W-1:TAG_LSB]) begin
         return RESP_DECERR;
      end
      return RESP_OKAY;
   endfunction

   // With RD_LAT=0 the read data is loaded on the AR handshake itself, so the
   // read port must look at the live AR address while idle.
   assign rd_addr = (state == IDLE) ? AR_ADDR : addr_q;
   assign rd_resp = decode(rd_addr);
   assign wr_resp = decode(addr_q);

   assign AR_READY = (state == IDLE);
   assign AW_READY = (state == IDLE) && !AR_VALID;
   assign W_READY  = (state == WR_DATA);
   assign R_VALID  = (state == RD_RESP);
   assign B_VALID  = (state == WR_RESP);

   axi_slave_mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (addr_q[TAG_LSB-1:2]),
      .wdata (W_DATA),
      .raddr (rd_addr[TAG_LSB-1:2]),
      .rdata (mem_rdata)
   );

   // NOTE: every output of this block gets a default before the case so that
   // no path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      latch_ar   = 1'b0;
      latch_aw   = 1'b0;
      load_rdata = 1'b0;
      load_bresp = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (AR_VALID) begin
               latch_ar = 1'b1;
               if (RD_LAT_C == '0) begin
                  state_nxt  = RD_RESP;
                  load_rdata = 1'b1;
               end else begin
                  state_nxt = RD_WAIT;
                  cnt_nxt   = RD_LAT_C;
               end
            end else if (AW_VALID) begin
               latch_aw  = 1'b1;
               state_nxt = WR_DATA;
            end
         end
         // The counter holds the number of idle cycles still to go including
         // the current one, so the last one is the cycle where it reads 1.
         RD_WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt  = RD_RESP;
               load_rdata = 1'b1;
            end
         end
         RD_RESP: begin
            if (R_READY) begin
               state_nxt = IDLE;
            end
         end
         WR_DATA: begin
            if (W_VALID) begin
               mem_we     = (wr_resp == RESP_OKAY);
               load_bresp = 1'b1;
               if (WR_LAT_C == '0) begin
                  state_nxt = WR_RESP;
               end else begin
                  state_nxt = WR_WAIT;
                  cnt_nxt   = WR_LAT_C;
               end
            end
         end
         WR_WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            if (B_READY) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
         R_DATA <= '0;
         R_RESP <= RESP_OKAY;
         B_RESP <= RESP_OKAY;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch_ar) begin
            addr_q <= AR_ADDR;
         end else if (latch_aw) begin
            addr_q <= AW_ADDR;
         end
         // Error reads return zero data.
         if (load_rdata) begin
            R_DATA <= (rd_resp == RESP_OKAY) ? mem_rdata : '0;
            R_RESP <= rd_resp;
         end
         if (load_bresp) begin
            B_RESP <= wr_resp;
         end
      end
   end

endmodule
